// File: rtl/io_port_responder_if.sv
// Strobe and hold-handshake signals between the bus owner and the I/O port responder.
// The multiplexed AD bus stays a plain inout on the module.
`timescale 1ns/1ps
interface io_port_responder_if;
  logic ALE;
  logic nIOR;
  logic nIOW;
  logic DReq;
  logic Hlda;
  logic Hrq;
  logic DAck;

  modport master (output ALE, nIOR, nIOW, DReq, Hlda, input Hrq, DAck);
  modport slave  (input ALE, nIOR, nIOW, DReq, Hlda, output Hrq, DAck);
endinterface

// File: rtl/io_port_responder.sv
// 8086-style I/O-space target with a 16 x 8 port file (port F is a read-only status)
// plus the requesting side of the Hrq/Hlda hold handshake for a peripheral DReq.
`timescale 1ns/1ps
module io_port_responder #(
  parameter logic [7:0] BASE_ADDR   = 8'h30,
  parameter int         HOLD_CYCLES = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  inout  wire  [15:0]        AD15_AD0,
  io_port_responder_if.slave bus
);

  typedef enum logic [3:0] {
    H_IDLE    = 4'b0001,
    H_REQ     = 4'b0010,
    H_GRANT   = 4'b0100,
    H_RELEASE = 4'b1000
  } hold_state_t;

  localparam logic [3:0] CNT_INIT = 4'(HOLD_CYCLES - 1);

  hold_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  xfer_q, xfer_d;
  logic [7:0]  addr_latch;
  logic [7:0]  regs [0:15];
  logic        prev_niow;
  logic        hit;
  logic [3:0]  idx;
  logic [7:0]  rdata;
  logic        drive;
  logic        wr_en;
  logic        hrq;
  logic        dack;

  assign hit   = (addr_latch[7:4] == BASE_ADDR[7:4]);
  assign idx   = addr_latch[3:0];
  assign wr_en = !bus.nIOW && prev_niow && hit && !bus.Hlda && (idx != 4'hF);
  assign drive = !bus.nIOR && hit && !bus.Hlda && !Reset;
  assign rdata = (idx == 4'hF) ? {hrq, dack, 2'b00, xfer_q} : regs[idx];

  // Only the upper byte is ever driven; the address half is left to the owner.
  assign AD15_AD0 = drive ? {rdata, 8'hzz} : 16'hzzzz;

  assign bus.Hrq  = hrq;
  assign bus.DAck = dack;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      addr_latch <= '0;
      prev_niow  <= 1'b1;
      state_q    <= H_IDLE;
      cnt_q      <= '0;
      xfer_q     <= '0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      if (bus.ALE) addr_latch <= AD15_AD0[7:0];
      // Strobes are floating while the owner holds the bus, so edge history is parked high.
      prev_niow <= bus.Hlda ? 1'b1 : bus.nIOW;
      if (wr_en) regs[idx] <= AD15_AD0[15:8];
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xfer_q  <= xfer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xfer_d  = xfer_q;
    hrq     = 1'b0;
    dack    = 1'b0;
    unique case (state_q)
      H_IDLE: begin
        if (bus.DReq && regs[0][0]) state_d = H_REQ;
      end
      H_REQ: begin
        hrq = 1'b1;
        if (bus.Hlda) begin
          state_d = H_GRANT;
          cnt_d   = CNT_INIT;
        end
      end
      H_GRANT: begin
        hrq  = 1'b1;
        dack = 1'b1;
        if (cnt_q == 4'd0) state_d = H_RELEASE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      H_RELEASE: begin
        if (!bus.Hlda) begin
          state_d = H_IDLE;
          xfer_d  = xfer_q + 4'd1;
        end
      end
      default: state_d = H_IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Scoreboard bench for io_port_responder: stimulus queues expected bus reads and
// per-cycle {Hrq,DAck} values; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_io_port_responder;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        tb_drive;
  logic [15:0] tb_ad;
  wire  [15:0] ad_bus;

  exp_t read_q[$];
  exp_t hold_q[$];
  exp_t mon_e;
  int   n_checks;
  int   n_fail;

  io_port_responder_if intf ();

  io_port_responder #(.BASE_ADDR(8'h30), .HOLD_CYCLES(4)) dut (
    .Clock    (clk),
    .Reset    (rst),
    .AD15_AD0 (ad_bus),
    .bus      (intf.slave)
  );

  // Undriven bus lines read back as 1, so "not driven" shows up as 8'hFF.
  pullup pu_ad (ad_bus);
  assign ad_bus = tb_drive ? tb_ad : 16'hzzzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (hold_q.size() > 0) begin
      mon_e = hold_q.pop_front();
      check_output(mon_e.name, {14'h0, intf.Hrq, intf.DAck}, mon_e.exp);
    end
    if (intf.nIOR == 1'b0) begin
      if (read_q.size() > 0) begin
        mon_e = read_q.pop_front();
        check_output(mon_e.name, ad_bus, mon_e.exp);
      end else begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL unexpected_read: got %h expected no read strobe", ad_bus);
      end
    end
  end

  task automatic push_read(input string name, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    read_q.push_back(e);
  endtask

  task automatic push_hold(input string name, input logic [1:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = {14'h0, exp};
    hold_q.push_back(e);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_latch(input logic [7:0] port);
    cycle();
    intf.ALE = 1'b1;
    tb_ad    = {8'h00, port};
    tb_drive = 1'b1;
    cycle();
    intf.ALE = 1'b0;
    tb_drive = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] port, input logic [7:0] data);
    cycle();
    intf.ALE = 1'b1;
    tb_ad    = {8'h00, port};
    tb_drive = 1'b1;
    cycle();
    intf.ALE  = 1'b0;
    intf.nIOW = 1'b0;
    tb_ad     = {data, 8'h00};
    cycle();
    intf.nIOW = 1'b1;
    tb_drive  = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] port, input logic [15:0] exp, input string name);
    cycle();
    intf.ALE = 1'b1;
    tb_ad    = {8'h00, port};
    tb_drive = 1'b1;
    cycle();
    intf.ALE  = 1'b0;
    tb_drive  = 1'b0;
    intf.nIOR = 1'b0;
    push_read(name, exp);
    cycle();
    intf.nIOR = 1'b1;
  endtask

  // mode 0: plain hold; mode 1: strobes to port 0x33 while granted; mode 2: reset in 2nd DAck cycle
  task automatic run_hold(input int mode);
    cycle();
    intf.DReq = 1'b1;
    push_hold("hold_idle", 2'b00);
    cycle();
    intf.DReq = 1'b0;
    push_hold("hrq_rise", 2'b10);
    cycle();
    intf.Hlda = 1'b1;
    push_hold("hrq_wait", 2'b10);
    for (int i = 0; i < 4; i++) begin
      cycle();
      push_hold("dack_high", 2'b11);
      if (mode == 1 && i == 0) begin
        intf.nIOW = 1'b0;
        tb_ad     = {8'hFF, 8'h33};
        tb_drive  = 1'b1;
      end
      if (mode == 1 && i == 1) begin
        intf.nIOW = 1'b1;
        tb_drive  = 1'b0;
        intf.nIOR = 1'b0;
        push_read("hold_no_drive", 16'hFFFF);
      end
      if (mode == 1 && i == 2) intf.nIOR = 1'b1;
      if (mode == 2 && i == 1) begin
        rst = 1'b1;
        break;
      end
    end
    cycle();
    rst       = 1'b0;
    intf.Hlda = 1'b0;
    push_hold((mode == 2) ? "reset_mid_hold" : "release_fall", 2'b00);
    cycle();
    push_hold("idle_after", 2'b00);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected test completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    tb_drive  = 1'b0;
    tb_ad     = '0;
    intf.ALE  = 1'b0;
    intf.nIOR = 1'b1;
    intf.nIOW = 1'b1;
    intf.DReq = 1'b0;
    intf.Hlda = 1'b0;

    cycle();
    push_hold("reset_outputs", 2'b00);
    cycle();
    rst = 1'b0;

    bus_read(8'h3F, 16'h00FF, "reset_status");
    bus_read(8'h31, 16'h00FF, "reset_reg1");

    bus_write(8'h32, 8'hA5);
    bus_read(8'h32, 16'hA5FF, "rw_reg2");

    bus_write(8'h52, 8'h77);
    bus_read(8'h52, 16'hFFFF, "miss_no_drive");
    bus_read(8'h32, 16'hA5FF, "miss_no_change");

    // A long nIOW pulse must only capture the data present on its first low cycle.
    apply_latch(8'h34);
    intf.nIOW = 1'b0;
    tb_ad     = {8'h11, 8'h00};
    tb_drive  = 1'b1;
    cycle();
    tb_ad = {8'h22, 8'h00};
    cycle();
    cycle();
    intf.nIOW = 1'b1;
    tb_drive  = 1'b0;
    bus_read(8'h34, 16'h11FF, "long_pulse_once");

    apply_latch(8'h35);
    intf.ALE  = 1'b1;
    intf.nIOW = 1'b0;
    tb_ad     = {8'h5A, 8'h45};
    tb_drive  = 1'b1;
    cycle();
    intf.ALE  = 1'b0;
    intf.nIOW = 1'b1;
    tb_drive  = 1'b0;
    bus_read(8'h35, 16'h5AFF, "ale_strobe_old_addr");
    bus_read(8'h45, 16'hFFFF, "ale_strobe_new_miss");

    cycle();
    intf.DReq = 1'b1;
    push_hold("no_enable_a", 2'b00);
    cycle();
    intf.DReq = 1'b0;
    push_hold("no_enable_b", 2'b00);
    cycle();
    push_hold("no_enable_c", 2'b00);

    bus_write(8'h30, 8'h01);
    run_hold(0);
    bus_read(8'h3F, 16'h01FF, "status_xfer1");

    bus_write(8'h33, 8'h3C);
    apply_latch(8'h33);
    run_hold(1);
    bus_read(8'h33, 16'h3CFF, "hold_no_write");

    run_hold(2);
    bus_read(8'h3F, 16'h00FF, "status_after_reset");
    bus_read(8'h30, 16'h00FF, "reg0_cleared");
    bus_read(8'h32, 16'h00FF, "reg2_cleared");

    bus_write(8'h30, 8'h01);
    for (int i = 0; i < 16; i++) begin
      run_hold(0);
      if (i == 14) bus_read(8'h3F, 16'h0FFF, "status_xfer15");
    end
    bus_read(8'h3F, 16'h00FF, "status_wrap");

    bus_write(8'h3F, 8'hEE);
    bus_read(8'h3F, 16'h00FF, "status_read_only");

    cycle();
    cycle();
    check_output("read_queue_drained", 16'(read_q.size()), 16'h0);
    check_output("hold_queue_drained", 16'(hold_q.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
